// File: rtl/ps2_move_if.sv
// PS/2 byte input and move/key-state outputs of the arrow-key decoder.
// The master side drives received bytes; the slave side drives the decoded results.
// There is no backpressure: each rx_en strobe carries exactly one byte.
interface ps2_move_if #(
  parameter int STEP_W = 8
);
  logic [7:0]          rx_data;
  logic                rx_en;
  logic [2*STEP_W-1:0] move;
  logic [3:0]          held;
  logic                move_changed;
  logic                pause;
  logic                proto_err;

  modport master (
    output rx_data, rx_en,
    input  move, held, move_changed, pause, proto_err
  );

  modport slave (
    input  rx_data, rx_en,
    output move, held, move_changed, pause, proto_err
  );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 arrow/pause decoder: parses E0/F0 prefixes and produces a registered signed {dx,dy} move.
// Latency: held/pause update on the edge that samples the completing byte; move follows one cycle later.
// No backpressure: a byte arriving in the cycle a prefix timeout fires is dropped.
module ps2_move_decoder #(
  parameter int          STEP_W         = 8,
  parameter int          LATCH_MODE     = 1,
  parameter int          REQUIRE_E0     = 0,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  PAUSE_CODE     = 8'h4D
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  ps2_move_if.slave    bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} pstate_t;
  typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  pstate_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout;
  logic             perr_nxt;
  logic             ev_vld, ev_brk, ev_ext;

  dir_t             cur, cur_nxt;
  logic [3:0]       held_nxt, key_mask;
  dir_t             key_dir;
  logic             arrow_ok;
  logic             pause_held, pause_held_nxt, pause_nxt;
  logic [2*STEP_W-1:0] move_nxt;

  function automatic logic [2*STEP_W-1:0] enc(input dir_t d);
    logic [STEP_W-1:0] one, neg, zro;
    one = {{(STEP_W-1){1'b0}}, 1'b1};
    neg = {STEP_W{1'b1}};
    zro = '0;
    case (d)
      D_UP:    enc = {zro, neg};
      D_DOWN:  enc = {zro, one};
      D_LEFT:  enc = {neg, zro};
      D_RIGHT: enc = {one, zro};
      default: enc = '0;
    endcase
  endfunction

  assign timeout = (state != S_IDLE) && (cnt == CNT_LAST);

  // Prefix parser: classify each byte as make/break, plain/extended, or a protocol error.
  always_comb begin
    state_nxt = state;
    perr_nxt  = 1'b0;
    ev_vld    = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    if (timeout) begin
      state_nxt = S_IDLE;
      perr_nxt  = 1'b1;
    end else if (bus.rx_en) begin
      case (state)
        S_IDLE: begin
          if (bus.rx_data == 8'hE0)      state_nxt = S_EXT;
          else if (bus.rx_data == 8'hF0) state_nxt = S_BRK;
          else                           ev_vld = 1'b1;
        end
        S_EXT: begin
          if (bus.rx_data == 8'hF0)      state_nxt = S_EXT_BRK;
          else if (bus.rx_data == 8'hE0) perr_nxt = 1'b1;
          else begin
            ev_vld    = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_nxt = S_IDLE;
          if (bus.rx_data == 8'hE0 || bus.rx_data == 8'hF0) perr_nxt = 1'b1;
          else begin
            ev_vld = 1'b1;
            ev_brk = 1'b1;
            ev_ext = (state == S_EXT_BRK);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    cnt_nxt = (timeout || bus.rx_en || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
  end

  // Parser state, prefix idle counter and error pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.proto_err <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.proto_err <= perr_nxt;
    end
  end

  // Key tracking: held mask, current direction arbitration and pause toggle.
  always_comb begin
    key_mask = 4'b0000;
    key_dir  = D_NONE;
    case (bus.rx_data)
      8'h75: begin key_mask = 4'b1000; key_dir = D_UP;    end
      8'h72: begin key_mask = 4'b0100; key_dir = D_DOWN;  end
      8'h6B: begin key_mask = 4'b0010; key_dir = D_LEFT;  end
      8'h74: begin key_mask = 4'b0001; key_dir = D_RIGHT; end
      default: ;
    endcase
    arrow_ok       = ev_vld && (key_mask != 4'b0000) && (ev_ext || REQUIRE_E0 == 0);
    held_nxt       = bus.held;
    cur_nxt        = cur;
    pause_nxt      = bus.pause;
    pause_held_nxt = pause_held;
    if (arrow_ok) begin
      if (!ev_brk) begin
        // A repeat make of a held key is typematic and must not steal priority.
        if ((bus.held & key_mask) == 4'b0000) begin
          held_nxt = bus.held | key_mask;
          cur_nxt  = key_dir;
        end
      end else begin
        held_nxt = bus.held & ~key_mask;
        if (cur == key_dir) begin
          if (held_nxt[3])          cur_nxt = D_UP;
          else if (held_nxt[2])     cur_nxt = D_DOWN;
          else if (held_nxt[1])     cur_nxt = D_LEFT;
          else if (held_nxt[0])     cur_nxt = D_RIGHT;
          else if (LATCH_MODE == 0) cur_nxt = D_NONE;
        end
      end
    end
    if (ev_vld && !ev_ext && bus.rx_data == PAUSE_CODE) begin
      if (ev_brk) pause_held_nxt = 1'b0;
      else if (!pause_held) begin
        pause_nxt      = ~bus.pause;
        pause_held_nxt = 1'b1;
      end
    end
    move_nxt = enc(cur);
  end

  // Key state registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bus.held   <= 4'b0000;
      cur        <= D_NONE;
      bus.pause  <= 1'b0;
      pause_held <= 1'b0;
    end else begin
      bus.held   <= held_nxt;
      cur        <= cur_nxt;
      bus.pause  <= pause_nxt;
      pause_held <= pause_held_nxt;
    end
  end

  // Move word registered one cycle behind the current direction, with change pulse.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      bus.move         <= '0;
      bus.move_changed <= 1'b0;
    end else begin
      bus.move         <= move_nxt;
      bus.move_changed <= (move_nxt != bus.move);
    end
  end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Bench for ps2_move_decoder: two instances (latched/no-E0 and stop/E0-required) share one byte stream.
// Expected move words are queued at stimulus time and popped by a monitor on each move_changed pulse.
// Direct checks cover held, pause, proto_err counts and the asynchronous reset.
module tb_ps2_move_decoder;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ps2_move_if #(.STEP_W(8)) if_a();
  ps2_move_if #(.STEP_W(8)) if_b();

  ps2_move_decoder #(.STEP_W(8), .LATCH_MODE(1), .REQUIRE_E0(0), .TIMEOUT_CYCLES(16),
                     .PAUSE_CODE(8'h4D))
    dut_a (.CLOCK_50(clk), .resetn(resetn), .bus(if_a.slave));
  ps2_move_decoder #(.STEP_W(8), .LATCH_MODE(0), .REQUIRE_E0(1), .TIMEOUT_CYCLES(16),
                     .PAUSE_CODE(8'h4D))
    dut_b (.CLOCK_50(clk), .resetn(resetn), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  int perr_a = 0;
  int perr_b = 0;
  int exp_perr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every move change must match the next queued expectation.
  always @(negedge clk) begin
    logic [15:0] e;
    if (resetn && if_a.move_changed) begin
      if (q_a.size() == 0) check("move_a_unexpected", {16'h0, if_a.move}, 32'hFFFF_FFFF);
      else begin e = q_a.pop_front(); check("move_a", {16'h0, if_a.move}, {16'h0, e}); end
    end
    if (resetn && if_b.move_changed) begin
      if (q_b.size() == 0) check("move_b_unexpected", {16'h0, if_b.move}, 32'hFFFF_FFFF);
      else begin e = q_b.pop_front(); check("move_b", {16'h0, if_b.move}, {16'h0, e}); end
    end
    if (if_a.proto_err) perr_a++;
    if (if_b.proto_err) perr_b++;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    if_a.rx_data = b; if_b.rx_data = b;
    if_a.rx_en = 1'b1; if_b.rx_en = 1'b1;
    @(negedge clk);
    if_a.rx_en = 1'b0; if_b.rx_en = 1'b0;
  endtask

  task automatic push_both(input logic [15:0] v);
    q_a.push_back(v);
    q_b.push_back(v);
  endtask

  task automatic check_held(input string name, input logic [3:0] ea, input logic [3:0] eb);
    check({name, "_a"}, {28'h0, if_a.held}, {28'h0, ea});
    check({name, "_b"}, {28'h0, if_b.held}, {28'h0, eb});
  endtask

  task automatic check_pause(input string name, input logic ep);
    check({name, "_a"}, {31'h0, if_a.pause}, {31'h0, ep});
    check({name, "_b"}, {31'h0, if_b.pause}, {31'h0, ep});
  endtask

  task automatic check_perr(input string name);
    idle(2);
    check({name, "_a"}, perr_a, exp_perr);
    check({name, "_b"}, perr_b, exp_perr);
  endtask

  initial begin
    resetn = 1'b0;
    if_a.rx_data = 8'h00; if_a.rx_en = 1'b0;
    if_b.rx_data = 8'h00; if_b.rx_en = 1'b0;
    idle(3);
    check("rst_move_a", {16'h0, if_a.move}, 32'h0);
    check("rst_move_b", {16'h0, if_b.move}, 32'h0);
    check_held("rst_held", 4'b0000, 4'b0000);
    check_pause("rst_pause", 1'b0);
    check("rst_perr", {31'h0, if_a.proto_err | if_b.proto_err}, 32'h0);
    resetn = 1'b1;
    idle(2);

    // Up press, then release (latched vs stop).
    push_both(16'h00FF);
    send(8'hE0); send(8'h75);
    check_held("up_held", 4'b1000, 4'b1000);
    q_b.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_held("up_rel", 4'b0000, 4'b0000);

    // Left then right, release right falls back to left.
    push_both(16'hFF00); send(8'hE0); send(8'h6B);
    push_both(16'h0100); send(8'hE0); send(8'h74);
    push_both(16'hFF00); send(8'hE0); send(8'hF0); send(8'h74);
    check_held("lr_held", 4'b0010, 4'b0010);
    q_b.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    idle(2);
    check("latch_left_a", {16'h0, if_a.move}, 32'h0000_FF00);

    // Down press/release: latched keeps 0001, stop mode returns to zero.
    push_both(16'h0001); send(8'hE0); send(8'h72);
    q_b.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h72);
    idle(2);
    check("latch_down_a", {16'h0, if_a.move}, 32'h0000_0001);
    check("stop_down_b", {16'h0, if_b.move}, 32'h0000_0000);
    check_held("down_rel", 4'b0000, 4'b0000);

    // Typematic up: one change only.
    push_both(16'h00FF);
    for (int i = 0; i < 5; i++) begin send(8'hE0); send(8'h75); end
    check_held("typ_held", 4'b1000, 4'b1000);
    q_b.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h75);

    // Pause: 4D,4D,F0,4D,4D toggles twice.
    send(8'h4D); check_pause("pause_1", 1'b1);
    send(8'h4D); check_pause("pause_rep", 1'b1);
    send(8'hF0); send(8'h4D); check_pause("pause_rel", 1'b1);
    send(8'h4D); check_pause("pause_2", 1'b0);

    // Timeout after a lone E0, then a plain up make.
    push_both(16'h0001); send(8'hE0); send(8'h72);
    q_b.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h72);
    send(8'hE0);
    idle(40);
    exp_perr = 1;
    check_perr("timeout_perr");
    q_a.push_back(16'h00FF);
    send(8'h75);
    idle(2);
    check("plain_up_b", {16'h0, if_b.move}, 32'h0);
    check_held("plain_up", 4'b1000, 4'b0000);
    send(8'hF0); send(8'h75);
    check_held("plain_rel", 4'b0000, 4'b0000);

    // Illegal prefixes: E0,E0 stays extended; F0,F0 aborts.
    push_both(16'hFF00);
    send(8'hE0); send(8'hE0); send(8'h6B);
    send(8'hF0); send(8'hF0);
    exp_perr = 3;
    check_perr("illegal_perr");
    check_held("illegal_held", 4'b0010, 4'b0010);
    q_b.push_back(16'h0000);
    send(8'hE0); send(8'hF0); send(8'h6B);

    // Asynchronous reset in the middle of an extended break with up held.
    push_both(16'h00FF); send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h4D); send(8'h4D);
    check_pause("pause_pre_rst", 1'b1);
    send(8'hE0); send(8'hF0);
    idle(1);
    #2 resetn = 1'b0;
    #1;
    check("arst_move_a", {16'h0, if_a.move}, 32'h0);
    check("arst_move_b", {16'h0, if_b.move}, 32'h0);
    check_held("arst_held", 4'b0000, 4'b0000);
    check_pause("arst_pause", 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    push_both(16'h0001); send(8'hE0); send(8'h72);
    idle(3);
    check_held("post_rst_held", 4'b0100, 4'b0100);

    idle(4);
    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
